// File: rtl/vector_execution_unit.sv
// Two-stage SIMD execute unit: stage 1 forms raw lane results, stage 2 wraps or
// saturates them and derives per-lane N/Z/V flags, with valid/ready flow control.
module vector_execution_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 6,
    parameter int FRAC_BITS  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [4:0]                      opcode,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] a,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic [NUM_LANES-1:0]            out_n,
    output logic [NUM_LANES-1:0]            out_z,
    output logic [NUM_LANES-1:0]            out_v,
    output logic                            out_illegal
);

    localparam int W  = DATA_WIDTH;
    localparam int RW = 2 * DATA_WIDTH;

    // Returns {saturated_or_overflowed, lane_value} from a raw 2W-bit lane result.
    function automatic logic [W:0] finish_lane(input logic signed [RW-1:0] raw,
                                               input logic fixed,
                                               input logic is_mul);
        logic signed [RW-1:0] val;
        logic signed [RW-1:0] max_v;
        logic signed [RW-1:0] min_v;
        logic [W:0]           res;
        max_v = {{(W+1){1'b0}}, {(W-1){1'b1}}};
        min_v = {{(W+1){1'b1}}, {(W-1){1'b0}}};
        val   = raw;
        if (fixed) begin
            if (is_mul) begin
                val = raw >>> FRAC_BITS;
            end else begin
                val = raw;
            end
            if (val > max_v) begin
                res = {1'b1, 1'b0, {(W-1){1'b1}}};
            end else if (val < min_v) begin
                res = {1'b1, 1'b1, {(W-1){1'b0}}};
            end else begin
                res = {1'b0, val[W-1:0]};
            end
        end else begin
            res = {(raw != {{W{raw[W-1]}}, raw[W-1:0]}), raw[W-1:0]};
        end
        return res;
    endfunction

    logic                          stall_s;
    logic                          illegal_s;
    logic signed [RW-1:0]          ext_a_s;
    logic signed [RW-1:0]          ext_b_s;
    logic signed [RW-1:0]          raw_s [NUM_LANES];
    logic [W:0]                    fin_s;
    logic [NUM_LANES*W-1:0]        s2_data_s;
    logic [NUM_LANES-1:0]          s2_n_s;
    logic [NUM_LANES-1:0]          s2_z_s;
    logic [NUM_LANES-1:0]          s2_v_s;

    logic                          s1_valid_r;
    logic [4:0]                    s1_opcode_r;
    logic                          s1_illegal_r;
    logic signed [RW-1:0]          s1_raw_r [NUM_LANES];
    logic                          s2_valid_r;
    logic [NUM_LANES*W-1:0]        s2_data_r;
    logic [NUM_LANES-1:0]          s2_n_r;
    logic [NUM_LANES-1:0]          s2_z_r;
    logic [NUM_LANES-1:0]          s2_v_r;
    logic                          s2_illegal_r;

    // A full, unconsumed stage 2 freezes the whole pipe; bubbles still advance.
    assign stall_s  = s2_valid_r && !out_ready;
    assign in_ready = !stall_s;

    // Stage-1 datapath: sign-extended raw add/sub/mul per lane.
    always_comb begin
        illegal_s = (opcode[4:3] == 2'b11) || (opcode[2:0] > 3'd2);
        ext_a_s   = '0;
        ext_b_s   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            ext_a_s = {{W{a[i*W+W-1]}}, a[i*W +: W]};
            ext_b_s = {{W{b[i*W+W-1]}}, b[i*W +: W]};
            case (opcode[2:0])
                3'b000:  raw_s[i] = ext_a_s + ext_b_s;
                3'b001:  raw_s[i] = ext_a_s - ext_b_s;
                3'b010:  raw_s[i] = ext_a_s * ext_b_s;
                default: raw_s[i] = '0;
            endcase
        end
    end

    // Stage-2 datapath: wrap/saturate, flags, scalar-lane masking and illegal squash.
    always_comb begin
        s2_data_s = '0;
        s2_n_s    = '0;
        s2_z_s    = '0;
        s2_v_s    = '0;
        fin_s     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            fin_s = finish_lane(s1_raw_r[i], s1_opcode_r[4:3] != 2'b00,
                                s1_opcode_r[2:0] == 3'b010);
            if (s1_illegal_r || (!s1_opcode_r[4] && i != 0)) begin
                s2_data_s[i*W +: W] = '0;
                s2_n_s[i]           = 1'b0;
                s2_z_s[i]           = 1'b0;
                s2_v_s[i]           = 1'b0;
            end else begin
                s2_data_s[i*W +: W] = fin_s[W-1:0];
                s2_n_s[i]           = fin_s[W-1];
                s2_z_s[i]           = (fin_s[W-1:0] == {W{1'b0}});
                s2_v_s[i]           = fin_s[W];
            end
        end
    end

    // Pipeline registers; both stages hold together while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_opcode_r  <= 5'b0;
            s1_illegal_r <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                s1_raw_r[i] <= '0;
            end
            s2_valid_r   <= 1'b0;
            s2_data_r    <= '0;
            s2_n_r       <= '0;
            s2_z_r       <= '0;
            s2_v_r       <= '0;
            s2_illegal_r <= 1'b0;
        end else if (!stall_s) begin
            s1_valid_r   <= in_valid;
            s1_opcode_r  <= opcode;
            s1_illegal_r <= illegal_s;
            for (int i = 0; i < NUM_LANES; i++) begin
                s1_raw_r[i] <= raw_s[i];
            end
            s2_valid_r   <= s1_valid_r;
            s2_data_r    <= s2_data_s;
            s2_n_r       <= s2_n_s;
            s2_z_r       <= s2_z_s;
            s2_v_r       <= s2_v_s;
            s2_illegal_r <= s1_illegal_r;
        end
    end

    assign out_valid   = s2_valid_r;
    assign out_data    = s2_data_r;
    assign out_n       = s2_n_r;
    assign out_z       = s2_z_r;
    assign out_v       = s2_v_r;
    assign out_illegal = s2_illegal_r;

endmodule
